// File: rtl/fp_tx_pkg.sv
// Shared types and constants for the byte-serial FP result transmitter.
// Frame layout: header {tag, NV, OF, UF, NX}, then the result MSB first.
package fp_tx_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_BYTE_W = 8;
  localparam int N_BYTES    = 1 + DEF_DATA_W / DEF_BYTE_W;
  localparam int FLAG_W     = 4;

  localparam logic [3:0] HDR_TAG = 4'hA;

  // Bit positions of the exception flags within res_flags.
  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SEND,
    WAIT_LOW
  } tx_state_e;

  function automatic logic [7:0] frame_header(input logic [FLAG_W-1:0] flags);
    return {HDR_TAG, flags[FLAG_NV], flags[FLAG_OF], flags[FLAG_UF], flags[FLAG_NX]};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for signals arriving from another clock domain.
// The enable freezes both stages so a globally disabled block sees no new input.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments make meta and q sample together, giving two
  // real flop stages; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else if (en) begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fp_result_tx.sv
// Sends one FP ALU result plus flags as a 5-byte frame over an 8-bit pin bus,
// using a four-phase strobe/ack handshake with an asynchronous host.
module fp_result_tx
  import fp_tx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BYTE_W = DEF_BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic [FLAG_W-1:0] res_flags,
  output logic [BYTE_W-1:0] uo_out,
  output logic              tx_strobe,
  input  logic              tx_ack,
  output logic              tx_last
);

  localparam int NB    = 1 + DATA_W / BYTE_W;
  localparam int CNT_W = $clog2(NB);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB - 1);

  tx_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              ack_s;
  logic              capture;

  sync_2ff #(.WIDTH(1)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ena),
    .d     (tx_ack),
    .q     (ack_s)
  );

  assign res_ready = ena && (state == IDLE);
  assign capture   = res_valid && res_ready;

  // uo_out is loaded on entry to SETUP so it is stable a full cycle before the
  // strobe rises, and it holds through WAIT_LOW until the next byte replaces it.
  // NOTE: the shift register is ordinary state, not a memory array, so it is
  // reset with everything else; an aborted frame leaves nothing to resend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      uo_out    <= '0;
      tx_strobe <= 1'b0;
      tx_last   <= 1'b0;
    end else if (ena) begin
      unique case (state)
        IDLE: begin
          if (capture) begin
            shreg  <= res_data;
            cnt    <= '0;
            uo_out <= BYTE_W'(frame_header(res_flags));
            state  <= SETUP;
          end
        end
        SETUP: begin
          // A host still holding ack from the previous byte stalls us here.
          if (!ack_s) begin
            tx_strobe <= 1'b1;
            tx_last   <= (cnt == LAST_CNT);
            state     <= SEND;
          end
        end
        SEND: begin
          if (ack_s) begin
            tx_strobe <= 1'b0;
            tx_last   <= 1'b0;
            state     <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!ack_s) begin
            if (cnt == LAST_CNT) begin
              uo_out <= '0;
              state  <= IDLE;
            end else begin
              cnt    <= cnt + 1'b1;
              uo_out <= shreg[DATA_W-1 -: BYTE_W];
              shreg  <= shreg << BYTE_W;
              state  <= SETUP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
